// File: rtl/wave_capture_pkg.sv
// Shared constants for the waveform capture block and its generator counterpart.
// Optional build macro used by the capture top: WAVE_CAPTURE_WRAP_EN.
package wave_capture_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = $clog2(WIDTH);
    localparam int unsigned BCNT_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

endpackage

// File: rtl/wave_capture_if.sv
// Host/stream-side signal bundle of wave_capture; master drives stimulus and reads back.
interface wave_capture_if;
    import wave_capture_pkg::*;

    logic              start;
    logic              wf_in;
    logic              wf_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              busy;
    logic              done;
    logic              byte_done;
    logic [BCNT_W-1:0] byte_count;
    logic              overflow;

    modport master (
        output start, wf_in, wf_valid, rd_addr,
        input  rd_data, busy, done, byte_done, byte_count, overflow
    );

    modport slave (
        input  start, wf_in, wf_valid, rd_addr,
        output rd_data, busy, done, byte_done, byte_count, overflow
    );

endinterface

// File: rtl/wave_deser.sv
// LSB-first serial-to-byte assembler: bit counter plus the lower WIDTH-1 shift bits.
module wave_deser
    import wave_capture_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             restart,
    input  logic             en,
    input  logic             bit_in,
    output logic             byte_ready_c,
    output logic [WIDTH-1:0] byte_value_c
);

    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-2:0] shift;

    // The final bit bypasses the register and is merged straight into the byte.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (restart) begin
            bit_cnt <= '0;
        end else if (en) begin
            if (bit_cnt != CNT_W'(WIDTH - 1))
                shift[bit_cnt] <= bit_in;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign byte_ready_c = en && (bit_cnt == CNT_W'(WIDTH - 1));
    assign byte_value_c = {bit_in, shift};

endmodule

// File: rtl/wave_capture.sv
// Serial waveform capture into a DEPTH-entry byte memory with a registered read port.
// Build macro WAVE_CAPTURE_WRAP_EN selects continuous (wrapping) capture.
module wave_capture
    import wave_capture_pkg::*;
(
    input  logic          clock,
    input  logic          clear,
    wave_capture_if.slave bus
);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              start_cap;
    logic              cap_en;
    logic              byte_ready;
    logic [WIDTH-1:0]  byte_value;
    logic [ADDR_W-1:0] wr_addr;
    logic [BCNT_W-1:0] byte_count;
    logic              busy;
    logic              done;
    logic              byte_done;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  mem [DEPTH];

    wave_deser u_deser (
        .clock        (clock),
        .clear        (clear),
        .restart      (start_cap),
        .en           (cap_en),
        .bit_in       (bus.wf_in),
        .byte_ready_c (byte_ready),
        .byte_value_c (byte_value)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next state plus the capture/arm strobes.
    always_comb begin
        next_state = state;
        start_cap  = 1'b0;
        cap_en     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    next_state = S_CAPTURE;
                    start_cap  = 1'b1;
                end
            end
            S_CAPTURE: begin
                cap_en = bus.wf_valid;
`ifndef WAVE_CAPTURE_WRAP_EN
                if (byte_ready && (wr_addr == ADDR_W'(DEPTH - 1)))
                    next_state = S_DONE;
`endif
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_addr    <= '0;
            byte_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_done  <= 1'b0;
        end else begin
            busy      <= (next_state == S_CAPTURE);
            done      <= (next_state == S_DONE);
            byte_done <= byte_ready;
            if (start_cap) begin
                wr_addr    <= '0;
                byte_count <= '0;
            end else if (byte_ready) begin
                wr_addr <= wr_addr + ADDR_W'(1);
                if (byte_count != BCNT_W'(DEPTH))
                    byte_count <= byte_count + BCNT_W'(1);
            end
        end
    end

    // Nonblocking write/read gives old data on a same-address collision.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++)
                mem[i] <= '0;
            rd_data <= '0;
        end else begin
            if (byte_ready)
                mem[wr_addr] <= byte_value;
            rd_data <= mem[bus.rd_addr];
        end
    end

`ifdef WAVE_CAPTURE_WRAP_EN
    logic overflow;

    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            overflow <= 1'b0;
        else if (start_cap)
            overflow <= 1'b0;
        else if (byte_ready && (wr_addr == ADDR_W'(DEPTH - 1)))
            overflow <= 1'b1;
    end

    assign bus.overflow = overflow;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.rd_data    = rd_data;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.byte_done  = byte_done;
    assign bus.byte_count = byte_count;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: single byte, gaps, async clear, full fill / wrap, restart.
module tb_wave_capture;

    logic clock;
    logic clear;
    int   vectors;
    int   miscompares;
    logic [7:0] rd;

    wave_capture_if bus ();

    wave_capture dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int b = 0; b < 8; b++) begin
            bus.wf_valid = 1'b1;
            bus.wf_in    = v[b];
            tick();
            if (gap > 0 && b != 7) begin
                bus.wf_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        bus.wf_valid = 1'b0;
    endtask

    task automatic read_mem(input logic [3:0] a, output logic [7:0] d);
        bus.rd_addr = a;
        tick();
        d = bus.rd_data;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        #2;
        clear = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] bits;
        vectors      = 0;
        miscompares  = 0;
        clear        = 1'b1;
        bus.start    = 1'b0;
        bus.wf_in    = 1'b0;
        bus.wf_valid = 1'b0;
        bus.rd_addr  = '0;
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_count", 32'(bus.byte_count), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_byte_done", 32'(bus.byte_done), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        clear = 1'b0;
        tick();

        // Single byte 0xA5 from the 1,0,1,0,0,1,0,1 bit sequence
        do_start();
        chk("arm_busy", 32'(bus.busy), 32'd1);
        bits = 8'hA5;
        for (int b = 0; b < 8; b++) begin
            bus.wf_valid = 1'b1;
            bus.wf_in    = bits[b];
            tick();
            if (b == 6) chk("bd_early", 32'(bus.byte_done), 32'd0);
        end
        bus.wf_valid = 1'b0;
        chk("bd_pulse", 32'(bus.byte_done), 32'd1);
        chk("one_count", 32'(bus.byte_count), 32'd1);
        read_mem(4'd0, rd);
        chk("bd_once", 32'(bus.byte_done), 32'd0);
        chk("mem0_a5", 32'(rd), 32'hA5);
        chk("one_busy", 32'(bus.busy), 32'd1);
        chk("one_done", 32'(bus.done), 32'd0);

        // Pre-start noise ignored, then 0x3C with 3-cycle gaps
        pulse_clear();
        for (int i = 0; i < 10; i++) begin
            bus.wf_valid = 1'b1;
            bus.wf_in    = 1'b1;
            tick();
        end
        bus.wf_valid = 1'b0;
        chk("noise_count", 32'(bus.byte_count), 32'd0);
        chk("noise_busy", 32'(bus.busy), 32'd0);
        do_start();
        send_byte(8'h3C, 3);
        chk("gap_count", 32'(bus.byte_count), 32'd1);
        read_mem(4'd0, rd);
        chk("mem0_3c", 32'(rd), 32'h3C);
        read_mem(4'd1, rd);
        chk("mem1_zero", 32'(rd), 32'h00);

        // Start in CAPTURE ignored; then async clear mid-byte
        do_start();
        chk("start_ign_count", 32'(bus.byte_count), 32'd1);
        bus.rd_addr = 4'd0;
        for (int b = 0; b < 5; b++) begin
            bus.wf_valid = 1'b1;
            bus.wf_in    = 1'b1;
            tick();
        end
        bus.wf_valid = 1'b0;
        #2;
        clear = 1'b1;
        #1;
        chk("clr_busy", 32'(bus.busy), 32'd0);
        chk("clr_count", 32'(bus.byte_count), 32'd0);
        chk("clr_rd_data", 32'(bus.rd_data), 32'd0);
        #1;
        clear = 1'b0;
        read_mem(4'd0, rd);
        chk("clr_mem0", 32'(rd), 32'h00);
        do_start();
        send_byte(8'hFF, 0);
        read_mem(4'd0, rd);
        chk("mem0_ff", 32'(rd), 32'hFF);

`ifndef WAVE_CAPTURE_WRAP_EN
        // Full fill, stop at DEPTH
        pulse_clear();
        do_start();
        for (int k = 0; k < 15; k++) send_byte(8'(k), 0);
        for (int b = 0; b < 7; b++) begin
            bus.wf_valid = 1'b1;
            bus.wf_in    = (b == 0 || b == 1 || b == 2 || b == 3);
            tick();
        end
        chk("pre_full_busy", 32'(bus.busy), 32'd1);
        chk("pre_full_done", 32'(bus.done), 32'd0);
        bus.wf_in = 1'b0;
        tick();
        bus.wf_valid = 1'b0;
        chk("full_done", 32'(bus.done), 32'd1);
        chk("full_busy", 32'(bus.busy), 32'd0);
        chk("full_count", 32'(bus.byte_count), 32'd16);
        send_byte(8'hEE, 0);
        chk("post_full_count", 32'(bus.byte_count), 32'd16);
        chk("post_full_done", 32'(bus.done), 32'd1);
        for (int k = 0; k < 16; k++) begin
            read_mem(4'(k), rd);
            chk($sformatf("fill_mem%0d", k), 32'(rd), 32'(k));
        end

        // Restart from DONE overwrites only entry 0
        do_start();
        chk("restart_done", 32'(bus.done), 32'd0);
        send_byte(8'h55, 0);
        chk("restart_count", 32'(bus.byte_count), 32'd1);
        read_mem(4'd0, rd);
        chk("restart_mem0", 32'(rd), 32'h55);
        read_mem(4'd1, rd);
        chk("restart_mem1", 32'(rd), 32'h01);
        chk("restart_busy", 32'(bus.busy), 32'd1);
        chk("restart_ovf", 32'(bus.overflow), 32'd0);
`else
        // Continuous capture wraps over entry 0
        pulse_clear();
        do_start();
        for (int k = 0; k < 17; k++) send_byte(8'(8'h10 + k), 0);
        chk("wrap_ovf", 32'(bus.overflow), 32'd1);
        chk("wrap_count", 32'(bus.byte_count), 32'd16);
        chk("wrap_busy", 32'(bus.busy), 32'd1);
        chk("wrap_done", 32'(bus.done), 32'd0);
        read_mem(4'd0, rd);
        chk("wrap_mem0", 32'(rd), 32'h20);
        read_mem(4'd1, rd);
        chk("wrap_mem1", 32'(rd), 32'h11);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
